mem_stream_scheduler: RTL and testbench
=======================================

Name: mem_stream_scheduler

Overview:
- Shares one external memory port between three streams of the accelerator chip: activation reads, weight reads and output writes.
- Generates sequential addresses per stream from programmed base/count values and absorbs memory read latency with per-stream credit FIFOs.
- Drives the chip's valid/ready input streams and its valid-only output stream.
- Sits between top_chip and the external memory model in the system wrapper, where all chip bandwidth is counted.

Parameters:
- MEM_BW, 128, memory/stream word width in bits
- ADDR_WIDTH, 20, word address width; also the width of the word counts
- RD_LATENCY, 2, fixed cycles from accepted read to mem_rdata; legal range ≥1
- FIFO_DEPTH, 4, words per stream FIFO; power of 2, ≥ RD_LATENCY+1

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse that launches a job; ignored while busy
- act_base, wgt_base, out_base  in  ADDR_WIDTH  start word address of each region, sampled on start
- act_words, wgt_words, out_words  in  ADDR_WIDTH  words per stream, sampled on start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when a job completes
- overflow_err  out  1  sticky: an output word was dropped
- act_data  out  MEM_BW; act_valid  out  1; act_ready  in  1  activation stream to chip
- wgt_data  out  MEM_BW; wgt_valid  out  1; wgt_ready  in  1  weight stream to chip
- out_data  in  MEM_BW; out_valid  in  1  chip output, no backpressure
- mem_req  out  1; mem_we  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  MEM_BW  memory request
- mem_ready  in  1  memory accepts the request this cycle
- mem_rdata  in  MEM_BW  read data

Behaviour:
- Clocking: one clock, clk. Reset rst_in is synchronous and active-high.
- Reset values: all outputs 0. FIFOs are emptied, the in-flight tag pipeline is cleared and state goes to IDLE.
- Reset mid-job: abandons the job. Read data still returning afterwards is discarded.
- States:
  - IDLE: start → RUN. Bases and counts are latched; remaining counters are loaded and overflow_err is cleared.
  - RUN: issue requests. Once all read requests have been issued → DRAIN.
  - DRAIN: wait until nothing is outstanding, both read FIFOs are empty and all out_words have been written. Then done=1 for one cycle → IDLE.
  - A stream with count 0 is complete immediately. If all counts are 0, done asserts 2 cycles after start.
  - busy=1 in RUN and DRAIN.
- Request eligibility:
  - Activation/weight read is eligible if words remain and fifo_count + outstanding < FIFO_DEPTH.
  - Output write is eligible if the output FIFO is non-empty.
- Arbitration, at most one grant per cycle:
  - Write has priority.
  - Reads alternate round-robin between activation and weights. The pointer advances only when a read is accepted (mem_req && mem_ready).
  - mem_req, mem_we, mem_addr and mem_wdata are combinational from the grant and are held stable while mem_ready=0.
- Address generation:
  - The address is base + issued_count, wrapping modulo 2^ADDR_WIDTH.
  - The count decrements on acceptance only.
- Read return:
  - A shift-register tag of depth RD_LATENCY records the stream id of each accepted read.
  - mem_rdata is pushed into the tagged FIFO exactly RD_LATENCY cycles after acceptance. The credit rule guarantees no FIFO overflow.
- Chip streams:
  - valid = FIFO non-empty; data = FIFO head. Pop on valid && ready.
  - The first word reaches the chip RD_LATENCY+1 cycles after grant.
- Output FIFO:
  - Pushes out_data when out_valid. A push while full is allowed only if a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow_err=1 (sticky until the next start), and the word still counts toward out_words.
  - out_valid outside RUN/DRAIN is ignored.
- Simultaneous events:
  - Push and pop in the same cycle on any FIFO keeps the count unchanged.
  - start during busy is ignored.
  - done and a new start in the same cycle: start is ignored.

Optional Feature:
- Macro: MEM_SCHED_BW_COUNTERS_EN.
- Defined: adds outputs bw_rd_words and bw_wr_words (32 bits each), counting accepted read and write memory transactions. They clear on reset only and saturate at all-ones.
- Undefined: the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package mem_sched_pkg contains:
  - typedef enum stream_e {STR_ACT, STR_WGT, STR_OUT}
  - typedef enum state_e {IDLE, RUN, DRAIN}
  - the constant BW_CNT_WIDTH = 32
- Sub-module stream_fifo (MEM_BW width, FIFO_DEPTH deep, registered, push/pop/count/full/empty), instantiated three times.

Test Plan:
- act_base=0x100, act_words=8, others 0, act_ready=1, RD_LATENCY=2 → mem_addr sequence 0x100..0x107 with no gaps, act_data in order, done pulses once.
- act_words=4, wgt_words=4, both ready=1 → grants alternate A,W,A,W…, 8 reads total, each stream receives its 4 words in address order.
- act_ready=0 for 20 cycles, act_words=16 → at most FIFO_DEPTH=4 activation reads issued, no data lost, resumes once ready=1.
- out_words=3, out_valid on 3 consecutive cycles with reads pending → writes preempt reads, mem_we=1 at out_base..out_base+2 carrying matching data.
- mem_ready=0 for 5 cycles mid-job → request fields held stable, counts unchanged, completion correct; out_valid bursting 6 words while mem_ready=0 → overflow_err=1 after the fifth word.
- rst_in asserted during RUN with 2 reads in flight → all outputs 0 next cycle, returning rdata not delivered; a new start with wgt_base=0x0FFFFF and wgt_words=2 → addresses 0xFFFFF, 0x00000.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared types for the memory stream scheduler: stream ids, FSM states, read-return tags.
package mem_sched_pkg;

  typedef enum logic [1:0] {STR_ACT, STR_WGT, STR_OUT} stream_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int BW_CNT_WIDTH = 32;

  typedef struct packed {
    logic    valid;
    stream_e id;
  } tag_t;

  function automatic logic [BW_CNT_WIDTH-1:0] sat_inc(input logic [BW_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + BW_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Registered circular FIFO; a push while full is taken only when a pop happens in the same cycle.
module stream_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic [$clog2(DEPTH):0] count,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_scheduler.sv
// Shares one memory port between activation reads, weight reads and output writes.
// Defining MEM_SCHED_BW_COUNTERS_EN adds saturating accepted read/write counters.
//
// state | meaning
// IDLE  | waiting for start; job parameters latched on start
// RUN   | issuing requests until every read has been accepted
// DRAIN | waiting for read returns, chip pops and remaining output writes
module mem_stream_scheduler
  import mem_sched_pkg::*;
#(
  parameter int MEM_BW     = 128,
  parameter int ADDR_WIDTH = 20,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] act_base,
  input  logic [ADDR_WIDTH-1:0] wgt_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic [ADDR_WIDTH-1:0] act_words,
  input  logic [ADDR_WIDTH-1:0] wgt_words,
  input  logic [ADDR_WIDTH-1:0] out_words,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err,
  output logic [MEM_BW-1:0]     act_data,
  output logic                  act_valid,
  input  logic                  act_ready,
  output logic [MEM_BW-1:0]     wgt_data,
  output logic                  wgt_valid,
  input  logic                  wgt_ready,
  input  logic [MEM_BW-1:0]     out_data,
  input  logic                  out_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_BW-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [MEM_BW-1:0]     mem_rdata
`ifdef MEM_SCHED_BW_COUNTERS_EN
  ,
  output logic [BW_CNT_WIDTH-1:0] bw_rd_words,
  output logic [BW_CNT_WIDTH-1:0] bw_wr_words
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] act_rem_q, wgt_rem_q, out_rem_q;
  logic [ADDR_WIDTH-1:0] act_addr_q, wgt_addr_q, out_addr_q;
  logic                  rr_wgt_q, hold_q, overflow_q;
  stream_e               hold_id_q;
  tag_t                  tag_q [RD_LATENCY];

  logic [CW-1:0]     act_count, wgt_count, out_count, act_inflight, wgt_inflight;
  logic [CW:0]       act_credit, wgt_credit;
  logic              act_full, act_empty, wgt_full, wgt_empty, out_full, out_empty;
  logic [MEM_BW-1:0] act_head, wgt_head, out_head;
  logic              act_elig, wgt_elig, wr_elig, gnt_valid, accept, all_done;
  logic              act_push, wgt_push, act_pop, wgt_pop, out_take, out_pop;
  stream_e           gnt_id;
  tag_t              ret_tag;

  stream_fifo #(.WIDTH(MEM_BW), .DEPTH(FIFO_DEPTH)) u_act_fifo (
    .clk, .rst_in, .push(act_push), .push_data(mem_rdata), .pop(act_pop),
    .head(act_head), .count(act_count), .full(act_full), .empty(act_empty));

  stream_fifo #(.WIDTH(MEM_BW), .DEPTH(FIFO_DEPTH)) u_wgt_fifo (
    .clk, .rst_in, .push(wgt_push), .push_data(mem_rdata), .pop(wgt_pop),
    .head(wgt_head), .count(wgt_count), .full(wgt_full), .empty(wgt_empty));

  stream_fifo #(.WIDTH(MEM_BW), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk, .rst_in, .push(out_take), .push_data(out_data), .pop(out_pop),
    .head(out_head), .count(out_count), .full(out_full), .empty(out_empty));

  assign ret_tag      = tag_q[RD_LATENCY-1];
  assign act_push     = ret_tag.valid && (ret_tag.id == STR_ACT);
  assign wgt_push     = ret_tag.valid && (ret_tag.id == STR_WGT);
  assign act_valid    = !act_empty;
  assign wgt_valid    = !wgt_empty;
  assign act_data     = act_empty ? '0 : act_head;
  assign wgt_data     = wgt_empty ? '0 : wgt_head;
  assign act_pop      = act_valid && act_ready;
  assign wgt_pop      = wgt_valid && wgt_ready;
  assign out_take     = busy && out_valid && (out_rem_q != '0);
  assign accept       = gnt_valid && mem_ready;
  assign out_pop      = accept && (gnt_id == STR_OUT);
  assign overflow_err = overflow_q;

  // Credits count reads still in the tag pipe, so a FIFO can never be overrun on return.
  always_comb begin
    act_inflight = '0;
    wgt_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (tag_q[i].valid && tag_q[i].id == STR_ACT) act_inflight = act_inflight + CW'(1);
      if (tag_q[i].valid && tag_q[i].id == STR_WGT) wgt_inflight = wgt_inflight + CW'(1);
    end
    act_credit = {1'b0, act_count} + {1'b0, act_inflight};
    wgt_credit = {1'b0, wgt_count} + {1'b0, wgt_inflight};
    act_elig   = busy && (act_rem_q != '0) && !act_full && (act_credit < (CW+1)'(FIFO_DEPTH));
    wgt_elig   = busy && (wgt_rem_q != '0) && !wgt_full && (wgt_credit < (CW+1)'(FIFO_DEPTH));
    wr_elig    = busy && !out_empty;
  end

  // A stalled request keeps its grant so the memory sees stable fields.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = STR_ACT;
    if (hold_q) begin
      gnt_valid = 1'b1;
      gnt_id    = hold_id_q;
    end else if (wr_elig) begin
      gnt_valid = 1'b1;
      gnt_id    = STR_OUT;
    end else if (act_elig && (!rr_wgt_q || !wgt_elig)) begin
      gnt_valid = 1'b1;
      gnt_id    = STR_ACT;
    end else if (wgt_elig) begin
      gnt_valid = 1'b1;
      gnt_id    = STR_WGT;
    end
  end

  always_comb begin
    mem_req   = gnt_valid;
    mem_we    = gnt_valid && (gnt_id == STR_OUT);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_valid) begin
      case (gnt_id)
        STR_ACT: mem_addr = act_addr_q;
        STR_WGT: mem_addr = wgt_addr_q;
        default: begin
          mem_addr  = out_addr_q;
          mem_wdata = out_head;
        end
      endcase
    end
  end

  assign all_done = (act_rem_q == '0) && (wgt_rem_q == '0) && (out_rem_q == '0) &&
                    (act_inflight == '0) && (wgt_inflight == '0) &&
                    (act_count == '0) && (wgt_count == '0) && (out_count == '0);

  always_ff @(posedge clk) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if ((act_rem_q == '0) && (wgt_rem_q == '0)) state_d = DRAIN;
      DRAIN:   if (all_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DRAIN) && all_done;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      act_rem_q  <= '0;
      wgt_rem_q  <= '0;
      out_rem_q  <= '0;
      act_addr_q <= '0;
      wgt_addr_q <= '0;
      out_addr_q <= '0;
      rr_wgt_q   <= 1'b0;
      hold_q     <= 1'b0;
      hold_id_q  <= STR_ACT;
      overflow_q <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      hold_q          <= gnt_valid && !mem_ready;
      hold_id_q       <= gnt_id;
      tag_q[0].valid  <= accept && (gnt_id != STR_OUT);
      tag_q[0].id     <= gnt_id;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (state_q == IDLE) begin
        if (start) begin
          act_rem_q  <= act_words;
          wgt_rem_q  <= wgt_words;
          out_rem_q  <= out_words;
          act_addr_q <= act_base;
          wgt_addr_q <= wgt_base;
          out_addr_q <= out_base;
          rr_wgt_q   <= 1'b0;
          overflow_q <= 1'b0;
        end
      end else begin
        if (accept) begin
          case (gnt_id)
            STR_ACT: begin
              act_rem_q  <= act_rem_q - ADDR_WIDTH'(1);
              act_addr_q <= act_addr_q + ADDR_WIDTH'(1);
              rr_wgt_q   <= 1'b1;
            end
            STR_WGT: begin
              wgt_rem_q  <= wgt_rem_q - ADDR_WIDTH'(1);
              wgt_addr_q <= wgt_addr_q + ADDR_WIDTH'(1);
              rr_wgt_q   <= 1'b0;
            end
            default: out_addr_q <= out_addr_q + ADDR_WIDTH'(1);
          endcase
        end
        // Dropped words still count toward the job's output total.
        if (out_take) begin
          out_rem_q <= out_rem_q - ADDR_WIDTH'(1);
          if (out_full && !out_pop) overflow_q <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_SCHED_BW_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst_in) begin
      bw_rd_words <= '0;
      bw_wr_words <= '0;
    end else if (accept) begin
      if (gnt_id == STR_OUT) bw_wr_words <= sat_inc(bw_wr_words);
      else                   bw_rd_words <= sat_inc(bw_rd_words);
    end
  end
`endif

endmodule

// File: tb/tb_mem_stream_scheduler.sv
// Directed bench: a fixed-latency memory model returns address-tagged data; accepted requests,
// chip-stream pops and done pulses are logged and compared with hand-computed values.
module tb_mem_stream_scheduler;
  localparam int MEM_BW = 128;
  localparam int AW     = 20;
  localparam int RDL    = 2;

  logic              clk = 1'b0;
  logic              rst_in = 1'b1, start = 1'b0;
  logic [AW-1:0]     act_base = '0, wgt_base = '0, out_base = '0;
  logic [AW-1:0]     act_words = '0, wgt_words = '0, out_words = '0;
  logic              busy, done, overflow_err;
  logic [MEM_BW-1:0] act_data, wgt_data, mem_wdata, mem_rdata;
  logic              act_valid, wgt_valid, mem_req, mem_we;
  logic              act_ready = 1'b1, wgt_ready = 1'b1, mem_ready = 1'b1;
  logic [MEM_BW-1:0] out_data = '0;
  logic              out_valid = 1'b0;
  logic [AW-1:0]     mem_addr;

  mem_stream_scheduler dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .act_base(act_base), .wgt_base(wgt_base), .out_base(out_base),
    .act_words(act_words), .wgt_words(wgt_words), .out_words(out_words),
    .busy(busy), .done(done), .overflow_err(overflow_err),
    .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
    .wgt_data(wgt_data), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .out_data(out_data), .out_valid(out_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  function automatic logic [MEM_BW-1:0] mdata(input logic [AW-1:0] a);
    return {8'hC3, 100'd0, a};
  endfunction

  function automatic logic [MEM_BW-1:0] wd(input int i);
    return {4{32'(32'hD0D0_0000 + i)}};
  endfunction

  // Memory model and event logs
  logic [MEM_BW-1:0] rd_pipe [RDL] = '{default: '0};
  int                cyc = 0, n_req = 0, n_act = 0, n_wgt = 0, n_done = 0;
  logic [AW-1:0]     req_addr  [512];
  logic              req_we    [512];
  logic [MEM_BW-1:0] req_wdata [512];
  int                req_cyc   [512];
  logic [MEM_BW-1:0] act_log   [512];
  int                act_cyc   [512];
  logic [MEM_BW-1:0] wgt_log   [512];

  assign mem_rdata = rd_pipe[RDL-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_pipe[0] <= (mem_req && mem_ready && !mem_we) ? mdata(mem_addr) : '0;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_req && mem_ready && n_req < 512) begin
      req_addr[n_req]  <= mem_addr;
      req_we[n_req]    <= mem_we;
      req_wdata[n_req] <= mem_wdata;
      req_cyc[n_req]   <= cyc;
      n_req <= n_req + 1;
    end
    if (act_valid && act_ready && n_act < 512) begin
      act_log[n_act] <= act_data;
      act_cyc[n_act] <= cyc;
      n_act <= n_act + 1;
    end
    if (wgt_valid && wgt_ready && n_wgt < 512) begin
      wgt_log[n_wgt] <= wgt_data;
      n_wgt <= n_wgt + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [MEM_BW-1:0] got, input logic [MEM_BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [AW-1:0] ab, input logic [AW-1:0] aw,
                        input logic [AW-1:0] wb, input logic [AW-1:0] ww,
                        input logic [AW-1:0] ob, input logic [AW-1:0] ow, output int s);
    @(negedge clk);
    act_base = ab; act_words = aw;
    wgt_base = wb; wgt_words = ww;
    out_base = ob; out_words = ow;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int k = 0;
    while (n_done == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 128'(n_done != d0), 128'(1));
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 128'(n_done - d0), 128'(1));
    check({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  task automatic wait_reqs(input string tag, input int r0, input int n, input int budget);
    int k = 0;
    while ((n_req - r0) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_req_wait"}, 128'((n_req - r0) >= n), 128'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, 128'({mem_req, mem_we, busy, done, overflow_err, act_valid, wgt_valid}), 128'(0));
    check({tag, "_addr"}, 128'(mem_addr), 128'(0));
    check({tag, "_wdata"}, mem_wdata, 128'(0));
    check({tag, "_act_data"}, act_data, 128'(0));
    check({tag, "_wgt_data"}, wgt_data, 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, r0, a0, w0, d0, k;
    int push_cyc [3];

    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_in = 1'b0;
    @(negedge clk);

    // 1: single activation stream, 8 words from 0x100
    r0 = n_req; a0 = n_act; d0 = n_done;
    launch(20'h100, 20'd8, '0, '0, '0, '0, s);
    wait_done("t1", d0, 200);
    check("t1_nreq", 128'(n_req - r0), 128'(8));
    check("t1_nact", 128'(n_act - a0), 128'(8));
    check("t1_first_grant", 128'(req_cyc[r0] - s), 128'(1));
    check("t1_latency", 128'(act_cyc[a0] - req_cyc[r0]), 128'(RDL + 1));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_addr%0d", i), 128'(req_addr[r0+i]), 128'(20'h100 + i));
      check($sformatf("t1_we%0d", i), 128'(req_we[r0+i]), 128'(0));
      check($sformatf("t1_gap%0d", i), 128'(req_cyc[r0+i] - req_cyc[r0]), 128'(i));
      check($sformatf("t1_data%0d", i), act_log[a0+i], mdata(AW'(20'h100 + i)));
    end

    // 2: act and wgt 4 words each, round-robin A,W,A,W
    r0 = n_req; a0 = n_act; w0 = n_wgt; d0 = n_done;
    launch(20'h200, 20'd4, 20'h300, 20'd4, '0, '0, s);
    wait_done("t2", d0, 200);
    check("t2_nreq", 128'(n_req - r0), 128'(8));
    for (int i = 0; i < 8; i++)
      check($sformatf("t2_addr%0d", i), 128'(req_addr[r0+i]),
            128'(((i % 2) == 0 ? 20'h200 : 20'h300) + i / 2));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_act%0d", i), act_log[a0+i], mdata(AW'(20'h200 + i)));
      check($sformatf("t2_wgt%0d", i), wgt_log[w0+i], mdata(AW'(20'h300 + i)));
    end

    // 3: chip not ready for 20 cycles, credits cap activation reads at FIFO depth
    act_ready = 1'b0;
    r0 = n_req; a0 = n_act; d0 = n_done;
    launch(20'h400, 20'd16, '0, '0, '0, '0, s);
    repeat (20) @(negedge clk);
    check("t3_capped_reads", 128'(n_req - r0), 128'(4));
    check("t3_act_valid", 128'(act_valid), 128'(1));
    check("t3_still_busy", 128'(busy), 128'(1));
    act_ready = 1'b1;
    wait_done("t3", d0, 300);
    check("t3_nreq", 128'(n_req - r0), 128'(16));
    check("t3_nact", 128'(n_act - a0), 128'(16));
    for (int i = 0; i < 16; i++)
      check($sformatf("t3_data%0d", i), act_log[a0+i], mdata(AW'(20'h400 + i)));

    // 4: three output words preempt pending activation reads
    r0 = n_req; d0 = n_done;
    launch(20'h600, 20'd8, '0, '0, 20'h500, 20'd3, s);
    for (int i = 0; i < 3; i++) begin
      out_valid = 1'b1;
      out_data  = wd(i);
      push_cyc[i] = cyc;
      @(negedge clk);
    end
    out_valid = 1'b0;
    wait_done("t4", d0, 300);
    k = 0;
    for (int j = r0; j < n_req; j++) begin
      if (req_we[j] && k < 3) begin
        check($sformatf("t4_waddr%0d", k), 128'(req_addr[j]), 128'(20'h500 + k));
        check($sformatf("t4_wdata%0d", k), req_wdata[j], wd(k));
        check($sformatf("t4_wcyc%0d", k), 128'(req_cyc[j] - push_cyc[k]), 128'(1));
        k++;
      end
    end
    check("t4_nwrites", 128'(k), 128'(3));
    check("t4_nreq", 128'(n_req - r0), 128'(11));

    // 5a: memory stalls for 5 cycles with a read pending
    r0 = n_req; a0 = n_act; d0 = n_done;
    launch(20'h700, 20'd6, '0, '0, '0, '0, s);
    wait_reqs("t5", r0, 2, 20);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t5_hold_req%0d", i), 128'({mem_req, mem_we}), 128'(2'b10));
      check($sformatf("t5_hold_addr%0d", i), 128'(mem_addr), 128'(20'h702));
      @(negedge clk);
    end
    check("t5_no_accept", 128'(n_req - r0), 128'(2));
    mem_ready = 1'b1;
    wait_done("t5", d0, 200);
    check("t5_nreq", 128'(n_req - r0), 128'(6));
    for (int i = 0; i < 6; i++)
      check($sformatf("t5_data%0d", i), act_log[a0+i], mdata(AW'(20'h700 + i)));
    check("t5_no_ovf", 128'(overflow_err), 128'(0));

    // 5b: six output words while memory refuses writes; fifth word overflows
    mem_ready = 1'b0;
    r0 = n_req; d0 = n_done;
    launch('0, '0, '0, '0, 20'h800, 20'd6, s);
    for (int i = 0; i < 4; i++) begin
      out_valid = 1'b1;
      out_data  = wd(10 + i);
      @(negedge clk);
    end
    check("t5_ovf_after4", 128'(overflow_err), 128'(0));
    out_data = wd(14);
    @(negedge clk);
    check("t5_ovf_after5", 128'(overflow_err), 128'(1));
    out_data = wd(15);
    @(negedge clk);
    out_valid = 1'b0;
    #1;
    check("t5_held_wdata", mem_wdata, wd(10));
    mem_ready = 1'b1;
    wait_done("t5b", d0, 200);
    check("t5_nwrites", 128'(n_req - r0), 128'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_waddr%0d", i), 128'(req_addr[r0+i]), 128'(20'h800 + i));
      check($sformatf("t5_wdata%0d", i), req_wdata[r0+i], wd(10 + i));
    end
    check("t5_ovf_sticky", 128'(overflow_err), 128'(1));

    // 6: reset with reads in flight, then a wrapping weight job
    r0 = n_req; d0 = n_done;
    launch(20'h900, 20'd8, '0, '0, '0, '0, s);
    check("t6_ovf_cleared", 128'(overflow_err), 128'(0));
    wait_reqs("t6", r0, 2, 20);
    rst_in = 1'b1;
    @(negedge clk);
    check_idle_outputs("t6_rst");
    a0 = n_act;
    rst_in = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_stale_pop", 128'(n_act - a0), 128'(0));
    check("t6_no_stale_valid", 128'(act_valid), 128'(0));
    r0 = n_req; w0 = n_wgt; d0 = n_done;
    launch('0, '0, 20'hFFFFF, 20'd2, '0, '0, s);
    wait_done("t6", d0, 100);
    check("t6_nreq", 128'(n_req - r0), 128'(2));
    check("t6_addr0", 128'(req_addr[r0]), 128'(20'hFFFFF));
    check("t6_addr1", 128'(req_addr[r0+1]), 128'(20'h00000));
    check("t6_wgt0", wgt_log[w0], mdata(20'hFFFFF));
    check("t6_wgt1", wgt_log[w0+1], mdata(20'h00000));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
